conv1d_seq: RTL

CONV1D_SEQ -- requirements
Module: conv1d_seq

---
 rtl/conv1d_pkg.sv | 35 +++
 rtl/conv1d_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_pkg.sv
// Shared definitions for the conv1d channel sequencer: datapath command
// codes, the filler command and the sequencer state encoding.
package conv1d_pkg;

  // Datapath command codes issued on cu_cmd
  localparam logic [6:0] CMD_KICK     = 7'd6;
  localparam logic [6:0] CMD_READ     = 7'd7;
  localparam logic [6:0] CMD_POLL     = 7'd9;
  localparam logic [6:0] CMD_LD_BIAS  = 7'd12;
  localparam logic [6:0] CMD_LD_MULT  = 7'd13;
  localparam logic [6:0] CMD_LD_SHIFT = 7'd14;

  // Filler command driven whenever no real command is issued
  localparam logic [6:0] NOP_CMD = 7'd127;

  // Table field selector carried in cfg_addr[5:4]
  localparam logic [1:0] FLD_BIAS  = 2'd0;
  localparam logic [1:0] FLD_MULT  = 2'd1;
  localparam logic [1:0] FLD_SHIFT = 2'd2;

  // One state per datapath step of a channel, plus IDLE
  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_BIAS,
    S_LD_MULT,
    S_LD_SHIFT,
    S_KICK,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_READ_ISSUE,
    S_READ_WAIT,
    S_EMIT
  } state_e;

endpackage

// File: rtl/conv1d_seq.sv
// Per-channel quantisation sequencer. For every channel it loads bias,
// multiplier and shift into an external datapath, kicks it, polls for
// completion, reads the result byte and hands it out on a valid/ready port.
//
// Result handshake: res_valid is raised in EMIT and stays high, with
// res_data and res_last held stable, until a cycle where res_valid and
// res_ready are both 1; the result is consumed on that clock edge.
module conv1d_seq #(
  parameter int          MAX_CH     = 16,
  parameter int          POLL_LIMIT = 4096,
  parameter logic [6:0]  NOP_CMD    = conv1d_pkg::NOP_CMD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        start,
  input  logic [4:0]  num_ch,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cu_en,
  output logic [6:0]  cu_cmd,
  output logic [31:0] cu_inp0,
  output logic [31:0] cu_inp1,
  input  logic [31:0] cu_ret,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_last
);
  import conv1d_pkg::*;

  localparam int              IW        = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int              PW        = $clog2(POLL_LIMIT + 1);
  localparam logic [4:0]      MAX_CH_N  = 5'(MAX_CH);
  localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_LIMIT - 1);

  state_e        state_q, state_d;

  // Quant tables; deliberately not reset so a run abort keeps them
  logic [31:0]   bias_tab  [MAX_CH];
  logic [31:0]   mult_tab  [MAX_CH];
  logic [31:0]   shift_tab [MAX_CH];

  logic [4:0]    num_q;
  logic [4:0]    ch_q;
  logic [PW-1:0] poll_q;
  logic [7:0]    res_q;
  logic          done_q;
  logic          err_q;

  logic [4:0]    num_clamped;
  logic [IW-1:0] ch_idx;
  logic [IW-1:0] wr_idx;
  logic          last_ch;
  logic          tab_we;

  // Control strobes produced by the next-state logic
  logic          take_start;
  logic          done_set;
  logic          err_set;
  logic          poll_clr;
  logic          poll_inc;
  logic          capture;
  logic          ch_adv;

  // Only the low result byte matters; upper datapath bits are ignored
  logic          unused_ret_bits;
  assign unused_ret_bits = ^cu_ret[31:8];

  assign num_clamped = (num_ch > MAX_CH_N) ? MAX_CH_N : num_ch;
  assign ch_idx      = ch_q[IW-1:0];
  assign wr_idx      = cfg_addr[IW-1:0];
  assign last_ch     = (ch_q == (num_q - 5'd1));
  assign busy        = (state_q != S_IDLE);
  assign tab_we      = cfg_we && !busy && (cfg_addr[5:4] != 2'd3) &&
                       (32'(cfg_addr[3:0]) < MAX_CH);

  assign done     = done_q;
  assign err      = err_q;
  assign res_data = res_q;
  assign cu_inp0  = 32'd0;

  // Table writes, accepted only while idle
  always_ff @(posedge clk) begin
    if (tab_we) begin
      case (cfg_addr[5:4])
        FLD_BIAS:  bias_tab[wr_idx]  <= cfg_data;
        FLD_MULT:  mult_tab[wr_idx]  <= cfg_data;
        FLD_SHIFT: shift_tab[wr_idx] <= cfg_data;
        default:   ;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Run bookkeeping: channel count, poll counter, result byte, flags
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      ch_q   <= '0;
      poll_q <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_set;
      if (take_start) begin
        num_q <= num_clamped;
        ch_q  <= '0;
        err_q <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (poll_clr)      poll_q <= '0;
      else if (poll_inc) poll_q <= poll_q + PW'(1);
      if (capture) res_q <= cu_ret[7:0];
      if (ch_adv)  ch_q  <= ch_q + 5'd1;
    end
  end

  // Next state, datapath command outputs and result handshake outputs
  always_comb begin
    state_d    = state_q;
    cu_en      = 1'b0;
    cu_cmd     = NOP_CMD;
    cu_inp1    = 32'd0;
    res_valid  = 1'b0;
    res_last   = 1'b0;
    take_start = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    poll_clr   = 1'b0;
    poll_inc   = 1'b0;
    capture    = 1'b0;
    ch_adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          // An empty run finishes immediately without touching the datapath
          if (num_clamped == 5'd0) done_set = 1'b1;
          else                     state_d  = S_LD_BIAS;
        end
      end
      S_LD_BIAS: begin
        cu_en   = 1'b1;
        cu_cmd  = CMD_LD_BIAS;
        cu_inp1 = bias_tab[ch_idx];
        state_d = S_LD_MULT;
      end
      S_LD_MULT: begin
        cu_en   = 1'b1;
        cu_cmd  = CMD_LD_MULT;
        cu_inp1 = mult_tab[ch_idx];
        state_d = S_LD_SHIFT;
      end
      S_LD_SHIFT: begin
        cu_en   = 1'b1;
        cu_cmd  = CMD_LD_SHIFT;
        cu_inp1 = shift_tab[ch_idx];
        state_d = S_KICK;
      end
      S_KICK: begin
        cu_en    = 1'b1;
        cu_cmd   = CMD_KICK;
        poll_clr = 1'b1;
        state_d  = S_POLL_ISSUE;
      end
      S_POLL_ISSUE: begin
        cu_en   = 1'b1;
        cu_cmd  = CMD_POLL;
        state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        cu_en = 1'b1;
        if (cu_ret[0]) begin
          state_d = S_READ_ISSUE;
        end else if (poll_q == POLL_LAST) begin
          // Datapath never finished: abandon the whole run
          err_set  = 1'b1;
          done_set = 1'b1;
          state_d  = S_IDLE;
        end else begin
          poll_inc = 1'b1;
          state_d  = S_POLL_ISSUE;
        end
      end
      S_READ_ISSUE: begin
        cu_en   = 1'b1;
        cu_cmd  = CMD_READ;
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        cu_en   = 1'b1;
        capture = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        res_valid = 1'b1;
        res_last  = last_ch;
        if (res_ready) begin
          if (last_ch) begin
            done_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ch_adv  = 1'b1;
            state_d = S_LD_BIAS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
